// File: rtl/ddc_hb_decim_chain.sv
// I/Q decimator built from up to NUM_STAGES cascaded x2 halfband stages.
// The active stage count is changed at runtime through a 2-cycle flush.
module ddc_hb_decim_chain #(
  parameter  int WIDTH      = 16,
  parameter  int NUM_STAGES = 3,
  localparam int SELW       = $clog2(NUM_STAGES + 1)
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic [WIDTH-1:0] i_inph_data,
  input  logic [WIDTH-1:0] i_quad_data,
  input  logic             i_valid,
  input  logic             i_cfg_valid,
  input  logic [SELW-1:0]  i_cfg_decim_log2,
  output logic [WIDTH-1:0] o_inph_data,
  output logic [WIDTH-1:0] o_quad_data,
  output logic             o_valid,
  output logic             o_cfg_busy,
  output logic [SELW-1:0]  o_decim_log2,
  output logic             o_sat
);

  localparam int ACCW = WIDTH + 6;
  localparam logic signed [ACCW-1:0] ACC_HI   = {{7{1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [ACCW-1:0] ACC_LO   = {{7{1'b1}}, {(WIDTH-1){1'b0}}};
  localparam logic signed [ACCW-1:0] RND_BIAS = 16;

  typedef logic signed [WIDTH-1:0] sample_t;
  typedef enum logic {RUN, FLUSH} state_t;

  state_t state;
  logic   flush_cnt;
  logic   clear;

  // Stored taps x1..x6; x0 is always the sample being accepted this cycle.
  sample_t dl_i [NUM_STAGES][6];
  sample_t dl_q [NUM_STAGES][6];
  logic [NUM_STAGES-1:0] phase;
  logic [NUM_STAGES-1:0] st_v;
  sample_t st_i [NUM_STAGES];
  sample_t st_q [NUM_STAGES];

  logic [NUM_STAGES-1:0] in_v;
  logic [NUM_STAGES-1:0] f_sat;
  sample_t in_i [NUM_STAGES];
  sample_t in_q [NUM_STAGES];
  sample_t f_i  [NUM_STAGES];
  sample_t f_q  [NUM_STAGES];
  logic    sel_v;
  sample_t sel_i;
  sample_t sel_q;

  // Returns {saturated, rounded and clamped tap output}.
  function automatic logic [WIDTH:0] hb_tap(sample_t x0, sample_t x2, sample_t x3,
                                            sample_t x4, sample_t x6);
    logic signed [ACCW-1:0] a0, a2, a3, a4, a6, pair, acc, rnd;
    a0   = x0;
    a2   = x2;
    a3   = x3;
    a4   = x4;
    a6   = x6;
    pair = a2 + a4;
    acc  = (a3 <<< 4) + (pair <<< 3) + pair - (a0 + a6);
    rnd  = (acc + RND_BIAS) >>> 5;
    if (rnd > ACC_HI) return {1'b1, ACC_HI[WIDTH-1:0]};
    if (rnd < ACC_LO) return {1'b1, ACC_LO[WIDTH-1:0]};
    return {1'b0, rnd[WIDTH-1:0]};
  endfunction

  always_comb begin
    logic [WIDTH:0] r_i, r_q;
    // NOTE: every combinational output gets a default before any branch, so no latch can be inferred.
    clear   = i_reset || i_cfg_valid || (state == FLUSH);
    in_v[0] = i_valid;
    in_i[0] = i_inph_data;
    in_q[0] = i_quad_data;
    for (int s = 1; s < NUM_STAGES; s++) begin
      in_v[s] = st_v[s-1];
      in_i[s] = st_i[s-1];
      in_q[s] = st_q[s-1];
    end
    for (int s = 0; s < NUM_STAGES; s++) begin
      r_i      = hb_tap(in_i[s], dl_i[s][1], dl_i[s][2], dl_i[s][3], dl_i[s][5]);
      r_q      = hb_tap(in_q[s], dl_q[s][1], dl_q[s][2], dl_q[s][3], dl_q[s][5]);
      f_i[s]   = r_i[WIDTH-1:0];
      f_q[s]   = r_q[WIDTH-1:0];
      f_sat[s] = r_i[WIDTH] | r_q[WIDTH];
    end
    sel_v = i_valid;
    sel_i = i_inph_data;
    sel_q = i_quad_data;
    for (int s = 0; s < NUM_STAGES; s++) begin
      if (o_decim_log2 == SELW'(s + 1)) begin
        sel_v = st_v[s];
        sel_i = st_i[s];
        sel_q = st_q[s];
      end
    end
  end

  // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge i_clock) begin
    // NOTE: the delay lines are tiny shift registers that must be cleared on flush anyway, so they share the reset.
    if (clear) begin
      for (int s = 0; s < NUM_STAGES; s++) begin
        for (int j = 0; j < 6; j++) begin
          dl_i[s][j] <= '0;
          dl_q[s][j] <= '0;
        end
        st_i[s] <= '0;
        st_q[s] <= '0;
      end
      phase       <= '0;
      st_v        <= '0;
      o_valid     <= 1'b0;
      o_inph_data <= '0;
      o_quad_data <= '0;
      o_sat       <= 1'b0;
    end else begin
      for (int s = 0; s < NUM_STAGES; s++) begin
        if (SELW'(s) >= o_decim_log2) begin
          for (int j = 0; j < 6; j++) begin
            dl_i[s][j] <= '0;
            dl_q[s][j] <= '0;
          end
          phase[s] <= 1'b0;
          st_v[s]  <= 1'b0;
          st_i[s]  <= '0;
          st_q[s]  <= '0;
        end else if (in_v[s]) begin
          for (int j = 5; j > 0; j--) begin
            dl_i[s][j] <= dl_i[s][j-1];
            dl_q[s][j] <= dl_q[s][j-1];
          end
          dl_i[s][0] <= in_i[s];
          dl_q[s][0] <= in_q[s];
          phase[s]   <= ~phase[s];
          st_v[s]    <= phase[s];
          if (phase[s]) begin
            st_i[s] <= f_i[s];
            st_q[s] <= f_q[s];
            if (f_sat[s]) o_sat <= 1'b1;
          end
        end else begin
          st_v[s] <= 1'b0;
        end
      end
      o_valid <= sel_v;
      if (sel_v) begin
        o_inph_data <= sel_i;
        o_quad_data <= sel_q;
      end
    end

    if (i_reset) begin
      state        <= RUN;
      flush_cnt    <= 1'b0;
      o_cfg_busy   <= 1'b0;
      o_decim_log2 <= SELW'(NUM_STAGES);
    end else if (i_cfg_valid) begin
      state        <= FLUSH;
      flush_cnt    <= 1'b0;
      o_cfg_busy   <= 1'b1;
      o_decim_log2 <= (i_cfg_decim_log2 > SELW'(NUM_STAGES)) ? SELW'(NUM_STAGES)
                                                              : i_cfg_decim_log2;
    end else if (state == FLUSH) begin
      if (flush_cnt) begin
        state      <= RUN;
        o_cfg_busy <= 1'b0;
      end
      flush_cnt <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ddc_hb_decim_chain.sv
// Scoreboard bench for ddc_hb_decim_chain: a sample-level halfband model predicts
// every output and its cycle; a negedge monitor pops and compares.
module tb_ddc_hb_decim_chain;

  localparam int W    = 16;
  localparam int NS   = 3;
  localparam int SELW = $clog2(NS + 1);
  localparam int MAXV = 32767;
  localparam int MINV = -32768;

  logic            i_clock = 1'b0;
  logic            i_reset = 1'b1;
  logic [W-1:0]    i_inph_data = '0;
  logic [W-1:0]    i_quad_data = '0;
  logic            i_valid = 1'b0;
  logic            i_cfg_valid = 1'b0;
  logic [SELW-1:0] i_cfg_decim_log2 = '0;
  logic [W-1:0]    o_inph_data;
  logic [W-1:0]    o_quad_data;
  logic            o_valid;
  logic            o_cfg_busy;
  logic [SELW-1:0] o_decim_log2;
  logic            o_sat;

  ddc_hb_decim_chain #(.WIDTH(W), .NUM_STAGES(NS)) dut (
    .i_clock          (i_clock),
    .i_reset          (i_reset),
    .i_inph_data      (i_inph_data),
    .i_quad_data      (i_quad_data),
    .i_valid          (i_valid),
    .i_cfg_valid      (i_cfg_valid),
    .i_cfg_decim_log2 (i_cfg_decim_log2),
    .o_inph_data      (o_inph_data),
    .o_quad_data      (o_quad_data),
    .o_valid          (o_valid),
    .o_cfg_busy       (o_cfg_busy),
    .o_decim_log2     (o_decim_log2),
    .o_sat            (o_sat)
  );

  always #5 i_clock = ~i_clock;

  int cyc = 0;
  always @(posedge i_clock) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  typedef struct {int cyc; int di; int dq;} exp_t;
  exp_t sb[$];

  int k_m;
  int hi [NS][7];
  int hq [NS][7];
  int cnt_m [NS];
  bit sat_m;
  int last_i;
  int last_q;

  task automatic check(input string name, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic hb(input int x0, input int x2, input int x3, input int x4, input int x6,
                    output int y, output bit s);
    int acc;
    acc = 16 * x3 + 9 * (x2 + x4) - (x0 + x6);
    y   = $rtoi($floor((acc + 16) / 32.0));
    s   = 1'b0;
    if (y > MAXV) begin y = MAXV; s = 1'b1; end
    if (y < MINV) begin y = MINV; s = 1'b1; end
  endtask

  task automatic model_clear(input int k);
    k_m   = k;
    sat_m = 1'b0;
    for (int s = 0; s < NS; s++) begin
      cnt_m[s] = 0;
      for (int j = 0; j < 7; j++) begin
        hi[s][j] = 0;
        hq[s][j] = 0;
      end
    end
    sb.delete();
  endtask

  // One accepted input sample, presented in cycle d, ripples through the k_m stages.
  task automatic model_in(input int d, input int xi, input int xq);
    int vi, vq;
    bit si, sq, done;
    vi = xi; vq = xq; done = 1'b0;
    for (int s = 0; s < k_m; s++) begin
      if (!done) begin
        for (int j = 6; j > 0; j--) begin
          hi[s][j] = hi[s][j-1];
          hq[s][j] = hq[s][j-1];
        end
        hi[s][0] = vi;
        hq[s][0] = vq;
        cnt_m[s]++;
        if (cnt_m[s] % 2 == 0) begin
          hb(hi[s][0], hi[s][2], hi[s][3], hi[s][4], hi[s][6], vi, si);
          hb(hq[s][0], hq[s][2], hq[s][3], hq[s][4], hq[s][6], vq, sq);
          if (si || sq) sat_m = 1'b1;
        end else begin
          done = 1'b1;
        end
      end
    end
    if (!done) sb.push_back('{d + 1 + k_m, vi, vq});
  endtask

  always @(negedge i_clock) begin
    if (!i_reset && o_valid) begin
      last_i = $signed(o_inph_data);
      last_q = $signed(o_quad_data);
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_out: o_valid=1 with I=%0d Q=%0d at cycle %0d, expected no output",
                 last_i, last_q, cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("out_i", last_i, e.di);
        check("out_q", last_q, e.dq);
        check("out_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic drive(input bit v, input int xi, input int xq);
    @(posedge i_clock); #1;
    i_valid     = v;
    i_inph_data = W'(xi);
    i_quad_data = W'(xq);
    if (v) model_in(cyc, xi, xq);
  endtask

  task automatic stream(input int n, input bit dc, input int amp);
    for (int i = 0; i < n; i++) begin
      int a, b;
      bit v;
      if (dc) begin
        a = MAXV; b = MINV; v = 1'b1;
      end else begin
        a = int'($urandom_range(0, 2 * amp)) - amp;
        b = int'($urandom_range(0, 2 * amp)) - amp;
        v = ($urandom_range(0, 3) != 0);
      end
      drive(v, a, b);
    end
  endtask

  task automatic drain();
    @(posedge i_clock); #1;
    i_valid = 1'b0;
    repeat (10) @(posedge i_clock);
    #1;
    check("drain_pending", sb.size(), 0);
    sb.delete();
  endtask

  // Loads a stage count (optionally pulsed twice) and checks the busy window;
  // i_valid is held high throughout so any leak into the pipeline shows up as output.
  task automatic cfg(input int v, input bit twice);
    logic [SELW-1:0] vv;
    int kexp;
    vv   = SELW'(v);
    kexp = (int'(vv) > NS) ? NS : int'(vv);
    @(posedge i_clock); #1;
    i_cfg_valid      = 1'b1;
    i_cfg_decim_log2 = vv;
    i_valid          = 1'b1;
    i_inph_data      = W'($urandom);
    i_quad_data      = W'($urandom);
    model_clear(kexp);
    @(posedge i_clock); #1;
    check("cfg_busy0", o_cfg_busy, 1);
    check("cfg_decim", o_decim_log2, kexp);
    check("cfg_sat_clr", o_sat, 0);
    if (twice) begin
      @(posedge i_clock); #1;
      check("cfg_busy_re", o_cfg_busy, 1);
    end
    i_cfg_valid = 1'b0;
    @(posedge i_clock); #1;
    check("cfg_busy1", o_cfg_busy, 1);
    check("cfg_valid_busy", o_valid, 0);
    @(posedge i_clock); #1;
    check("cfg_busy_end", o_cfg_busy, 0);
    check("cfg_valid_exit", o_valid, 0);
    i_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge i_clock); #1;
    i_reset          = 1'b1;
    i_valid          = 1'b0;
    i_cfg_valid      = 1'b1;
    i_cfg_decim_log2 = SELW'(1);
    sb.delete();
    @(posedge i_clock); #1;
    check("rst_valid", o_valid, 0);
    check("rst_i", $signed(o_inph_data), 0);
    check("rst_q", $signed(o_quad_data), 0);
    check("rst_busy", o_cfg_busy, 0);
    check("rst_sat", o_sat, 0);
    check("rst_decim", o_decim_log2, NS);
    i_reset     = 1'b0;
    i_cfg_valid = 1'b0;
    model_clear(NS);
  endtask

  initial begin
    repeat (3) @(posedge i_clock);
    #1;
    check("por_valid", o_valid, 0);
    check("por_i", $signed(o_inph_data), 0);
    check("por_q", $signed(o_quad_data), 0);
    check("por_busy", o_cfg_busy, 0);
    check("por_sat", o_sat, 0);
    check("por_decim", o_decim_log2, NS);
    i_reset = 1'b0;
    model_clear(NS);

    stream(60, 1'b0, 2000);
    drain();
    check("sat_k3_small", o_sat, sat_m);

    cfg(1, 1'b0);
    drive(1'b1, 0, 0);
    drive(1'b1, 1024, 0);
    for (int i = 0; i < 6; i++) drive(1'b1, 0, 0);
    drain();
    check("impulse_last_i", last_i, -32);

    stream(60, 1'b0, 32767);
    drain();
    check("sat_k1_full", o_sat, sat_m);

    cfg(1, 1'b0);
    begin
      int pat [8];
      pat = '{100, MINV, 0, MAXV, MAXV, MAXV, 0, MINV};
      for (int i = 0; i < 8; i++) drive(1'b1, pat[i], 0);
    end
    drain();
    check("satpat_i", last_i, MAXV);
    check("satpat_flag", o_sat, 1);
    check("satpat_model", o_sat, sat_m);

    cfg(2, 1'b1);
    check("sat_after_cfg", o_sat, 0);
    stream(80, 1'b0, 8000);
    drain();
    check("sat_k2", o_sat, sat_m);

    cfg(3, 1'b0);
    stream(80, 1'b1, 0);
    drain();
    check("dc_i", last_i, MAXV);
    check("dc_q", last_q, MINV);
    check("dc_sat", o_sat, sat_m);

    cfg(0, 1'b0);
    drive(1'b1, 5, -5);
    drain();
    check("bypass_i", last_i, 5);
    check("bypass_q", last_q, -5);
    stream(30, 1'b0, 32767);
    drain();

    cfg(7, 1'b0);
    stream(40, 1'b0, 4000);
    drain();

    cfg(2, 1'b0);
    stream(13, 1'b0, 4000);
    do_reset();
    stream(60, 1'b0, 4000);
    drain();
    check("sat_post_reset", o_sat, sat_m);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running at time limit, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
